// File: rtl/sprite_rom_pkg.sv
// Shared constants and pipeline tag type for the sprite/digit ROM path.
// Used by the arbiter, the ROM wrappers and the draw units.
package sprite_rom_pkg;
  localparam int          ADDR_W    = 13;
  localparam int          DATA_W    = 8;
  localparam int          ROM_DEPTH = 7008;
  localparam logic [7:0]  OOB_PIXEL = 8'h00;

  typedef struct packed {
    logic       valid;
    logic [2:0] id;
    logic       oob;
  } tag_t;
endpackage

// File: rtl/sprite_rom_arbiter_rr.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);
  always_comb begin
    int unsigned j;
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!gnt_any && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
        gnt_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port sprite ROM among NUM_REQ requesters; round-robin grant,
// one read per cycle, responses returned two cycles after grant tagged by requester.
module sprite_rom_arbiter
  import sprite_rom_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                      clk_pix,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      oob_err,
  input  logic                      clr_err
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d, gnt_idx;
  logic              gnt_any, gnt_oob;
  logic [ADDR_W-1:0] gnt_addr, addr_q, addr_d;
  tag_t              tag1_q, tag1_d, tag2_q, tag2_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              oob_err_q, oob_err_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    gnt_addr = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    gnt_oob  = gnt_any && (int'(gnt_addr) >= ROM_DEPTH);

    rr_ptr_d = gnt_any ? IDX_W'((int'(gnt_idx) + 1) % NUM_REQ) : rr_ptr_q;
    // OOB grants leave the ROM address parked so the ROM input never toggles needlessly.
    addr_d   = (gnt_any && !gnt_oob) ? gnt_addr : addr_q;

    tag1_d       = '0;
    tag1_d.valid = gnt_any;
    tag1_d.id    = 3'(gnt_idx);
    tag1_d.oob   = gnt_oob;
    tag2_d       = tag1_q;

    rsp_data_d = rsp_data_q;
    if (tag1_q.valid) rsp_data_d = tag1_q.oob ? OOB_PIXEL : rom_data;

    // A fresh OOB grant beats a simultaneous clear.
    oob_err_d = (oob_err_q && !clr_err) || gnt_oob;
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      addr_q     <= '0;
      tag1_q     <= '0;
      tag2_q     <= '0;
      rsp_data_q <= '0;
      oob_err_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      addr_q     <= addr_d;
      tag1_q     <= tag1_d;
      tag2_q     <= tag2_d;
      rsp_data_q <= rsp_data_d;
      oob_err_q  <= oob_err_d;
    end
  end

  assign rom_addr  = addr_d;
  assign rsp_valid = tag2_q.valid ? (NUM_REQ'(1) << tag2_q.id) : '0;
  assign rsp_data  = rsp_data_q;
  assign oob_err   = oob_err_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter; the ROM model returns addr[7:0] ^ 8'hB5.
module tb_sprite_rom_arbiter;
  localparam int NR = 4;
  localparam int AW = 13;

  logic          clk_pix = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0] req_ready;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [NR-1:0] rsp_valid;
  logic [7:0]    rsp_data;
  logic          oob_err;
  logic          clr_err;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp3 [4] = '{8'h95, 8'h94, 8'h97, 8'h96};

  sprite_rom_arbiter #(.NUM_REQ(NR)) dut (
    .clk_pix   (clk_pix),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .oob_err   (oob_err),
    .clr_err   (clr_err)
  );

  always #5 clk_pix = ~clk_pix;

  always @(posedge clk_pix) rom_data <= rom_addr[7:0] ^ 8'hB5;

  task automatic tick();
    @(negedge clk_pix);
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr_err = 1'b0; req_valid = '1; req_addr = '0;
    for (int i = 0; i < NR; i++) set_addr(i, AW'(13'h0050 + i));

    // reset with all requesters active
    repeat (2) begin
      tick(); #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_oob_err", oob_err, 0);
    end
    tick(); rst_n = 1'b1; req_valid = '0; #1;
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_oob_err", oob_err, 0);
    tick(); #1;
    chk("post_rst2_rsp_valid", rsp_valid, 0);

    // all four requesting continuously, rotation from 0
    for (int i = 0; i < NR; i++) set_addr(i, AW'(13'h0020 + i));
    for (int k = 0; k < 10; k++) begin
      tick(); req_valid = (k < 8) ? 4'hF : 4'h0; #1;
      if (k < 8) begin
        chk("rr_ready", req_ready, 1 << (k % 4));
        chk("rr_rom_addr", rom_addr, 32'h20 + (k % 4));
      end
      if (k >= 2) begin
        chk("rr_rsp_valid", rsp_valid, 1 << ((k - 2) % 4));
        chk("rr_rsp_data", rsp_data, exp3[(k - 2) % 4]);
      end
    end

    // single request from requester 2
    tick(); req_valid = 4'b0100; set_addr(2, 13'h0010); #1;
    chk("single_ready", req_ready, 4'b0100);
    chk("single_rom_addr", rom_addr, 13'h0010);
    tick(); req_valid = '0; #1;
    chk("single_n1_rsp_valid", rsp_valid, 0);
    tick(); #1;
    chk("single_rsp_valid", rsp_valid, 4'b0100);
    chk("single_rsp_data", rsp_data, 8'hA5);
    tick(); #1;
    chk("hold_rsp_valid", rsp_valid, 0);
    chk("hold_rsp_data", rsp_data, 8'hA5);

    // out-of-bounds read at exactly ROM_DEPTH
    tick(); req_valid = 4'b0010; set_addr(1, 13'd7008); #1;
    chk("oob_ready", req_ready, 4'b0010);
    chk("oob_rom_addr", rom_addr, 13'h0010);
    tick(); req_valid = '0; #1;
    chk("oob_err_set", oob_err, 1);
    chk("oob_rom_addr_held", rom_addr, 13'h0010);
    tick(); #1;
    chk("oob_rsp_valid", rsp_valid, 4'b0010);
    chk("oob_rsp_data", rsp_data, 8'h00);
    tick(); clr_err = 1'b1; #1;
    tick(); clr_err = 1'b0; #1;
    chk("oob_err_clr", oob_err, 0);
    // clear coincident with a new OOB grant: set wins
    tick(); clr_err = 1'b1; req_valid = 4'b0010; set_addr(1, 13'h1FFF); #1;
    chk("oob2_ready", req_ready, 4'b0010);
    tick(); clr_err = 1'b0; req_valid = '0; #1;
    chk("oob_set_wins", oob_err, 1);
    tick(); clr_err = 1'b1; #1;
    tick(); clr_err = 1'b0; #1;
    chk("oob_err_clr2", oob_err, 0);
    // last in-bounds word
    tick(); req_valid = 4'b0001; set_addr(0, 13'd7007); #1;
    chk("edge_ready", req_ready, 4'b0001);
    chk("edge_rom_addr", rom_addr, 13'd7007);
    tick(); req_valid = '0; #1;
    chk("edge_no_oob", oob_err, 0);
    tick(); #1;
    chk("edge_rsp_valid", rsp_valid, 4'b0001);
    chk("edge_rsp_data", rsp_data, 8'hEA);

    // reset while two reads are in flight
    tick(); req_valid = 4'b1000; set_addr(3, 13'h0030); #1;
    chk("mid_ready_n", req_ready, 4'b1000);
    tick(); rst_n = 1'b0; req_valid = 4'b0001; set_addr(0, 13'h0031); #1;
    chk("mid_ready_n1", req_ready, 4'b0001);
    tick(); rst_n = 1'b1; req_valid = '0; #1;
    chk("mid_rsp_valid_n2", rsp_valid, 0);
    chk("mid_rsp_data_n2", rsp_data, 0);
    tick(); #1;
    chk("mid_rsp_valid_n3", rsp_valid, 0);

    // idle: address parked, pointer held
    tick(); req_valid = 4'b0010; set_addr(1, 13'h0040); #1;
    chk("idle_pre_ready", req_ready, 4'b0010);
    for (int k = 0; k < 10; k++) begin
      tick(); req_valid = '0; #1;
      chk("idle_rom_addr", rom_addr, 13'h0040);
    end
    tick(); req_valid = 4'hF; #1;
    chk("idle_ptr_ready", req_ready, 4'b0100);
    tick(); req_valid = 4'b0100; #1;
    chk("regrant_alone", req_ready, 4'b0100);
    tick(); req_valid = 4'b0101; #1;
    chk("regrant_yield", req_ready, 4'b0001);
    tick(); req_valid = '0; #1;
    chk("drop_ready", req_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
